// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start detection, mid-bit sampling, one-cycle
// data-ready and frame-error strobes.
module uart_receiver #(
  parameter int unsigned ClkFrequency = 12000000,
  parameter int unsigned Baud         = 115200,
  parameter int unsigned Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_error,
  output logic       RxD_busy
);

  localparam int unsigned Div  = (ClkFrequency + Baud * Oversampling / 2) /
                                 (Baud * Oversampling);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned OsW  = $clog2(Oversampling);

  localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);
  localparam logic [OsW-1:0]  OsMax  = OsW'(Oversampling - 1);
  localparam logic [OsW-1:0]  OsHalf = OsW'(Oversampling / 2 - 1);

  if (Div < 2) begin : gen_div_check
    $error("uart_receiver: clocks per sample tick (Div) must be at least 2");
  end
  if ((Oversampling < 4) || (Oversampling % 2 != 0)) begin : gen_os_check
    $error("uart_receiver: Oversampling must be even and at least 4");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q;
  logic            rx_meta_q, rxs_q;
  logic [DivW-1:0] div_cnt_q;
  logic [OsW-1:0]  os_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shreg_q;
  logic [7:0]      data_q;
  logic            ready_q, ferr_q;

  logic           tick;
  logic [OsW-1:0] os_next;

  assign tick    = (state_q != StIdle) && (div_cnt_q == DivMax);
  assign os_next = (os_cnt_q == OsMax) ? '0 : os_cnt_q + OsW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RxD;
      rxs_q     <= rx_meta_q;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;

      if (state_q == StIdle || tick) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DivW'(1);
      end
      if (tick) begin
        os_cnt_q <= os_next;
      end

      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_q   <= StStart;
            div_cnt_q <= '0;
            os_cnt_q  <= '0;
          end
        end
        StStart: begin
          // Mid start bit: a high line here means the falling edge was a glitch.
          if (tick && os_cnt_q == OsHalf) begin
            if (rxs_q) begin
              state_q <= StIdle;
            end else begin
              os_cnt_q  <= '0;
              bit_cnt_q <= '0;
              state_q   <= StData;
            end
          end
        end
        StData: begin
          if (tick && os_cnt_q == OsMax) begin
            shreg_q   <= {rxs_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              os_cnt_q <= '0;
              state_q  <= StStop;
            end
          end
        end
        StStop: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
          if (tick && os_cnt_q == OsMax) begin
            if (rxs_q) begin
              data_q  <= shreg_q;
              ready_q <= 1'b1;
              state_q <= StIdle;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rxs_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RxD_data        = data_q;
  assign RxD_data_ready  = ready_q;
  assign RxD_frame_error = ferr_q;
  assign RxD_busy        = (state_q != StIdle);

endmodule
